// File: rtl/log_mult_pkg.sv
// Shared types for the log-multiplier scheduler: operand/result types, the S1
// pipeline entry, and a leading-one helper used by the multiplier.
package log_mult_pkg;

  localparam int OP_W     = 8;
  localparam int RES_W    = 16;
  localparam int ID_MAX_W = 3;

  typedef logic signed [OP_W-1:0]  op_t;
  typedef logic signed [RES_W-1:0] res_t;

  // id is sized for the largest supported requester count (8)
  typedef struct packed {
    logic                valid;
    logic [ID_MAX_W-1:0] id;
    op_t                 a;
    op_t                 b;
  } s1_t;

  function automatic logic [2:0] lead_one(input logic [OP_W-1:0] v);
    lead_one = '0;
    for (int i = 0; i < OP_W; i++) begin
      if (v[i]) lead_one = 3'(i);
    end
  endfunction

endpackage

// File: rtl/log_multiplier.sv
// Combinational signed 8x8 Mitchell logarithmic multiplier: exact for powers of
// two, approximate otherwise. Zero on either operand gives zero.
module log_multiplier
  import log_mult_pkg::*;
(
  input  op_t  A,
  input  op_t  B,
  output res_t P
);

  logic [OP_W-1:0] mag_a, mag_b;
  logic [2:0]      k_a, k_b;
  logic [6:0]      frac_a, frac_b;
  logic [10:0]     l_sum;
  logic [3:0]      charac;
  logic [15:0]     mant, mag_p;

  always_comb begin
    mag_a  = A[OP_W-1] ? -A : A;
    mag_b  = B[OP_W-1] ? -B : B;
    k_a    = lead_one(mag_a);
    k_b    = lead_one(mag_b);
    frac_a = 7'(mag_a << (3'd7 - k_a));
    frac_b = 7'(mag_b << (3'd7 - k_b));
    // log2 approximations as k.frac fixed point, summed then linearly antilogged
    l_sum  = {1'b0, k_a, frac_a} + {1'b0, k_b, frac_b};
    charac = l_sum[10:7];
    mant   = {8'd0, 1'b1, l_sum[6:0]};
    if (charac >= 4'd7) mag_p = mant << (charac - 4'd7);
    else                mag_p = mant >> (4'd7 - charac);
    if (mag_a == '0 || mag_b == '0) P = '0;
    else if (A[OP_W-1] ^ B[OP_W-1]) P = -res_t'(mag_p);
    else                             P = res_t'(mag_p);
  end

endmodule

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: searches from ptr+1 (wrapping) and picks the
// first active request, giving a one-hot win vector and its index.
module rr_arbiter #(
  parameter int N_REQ = 4,
  parameter int IDX_W = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N_REQ-1:0] win,
  output logic [IDX_W-1:0] win_idx
);

  logic [IDX_W-1:0] cand;
  logic             found;

  always_comb begin
    win     = '0;
    win_idx = '0;
    found   = 1'b0;
    cand    = ptr;
    for (int off = 0; off < N_REQ; off++) begin
      cand = (cand == IDX_W'(N_REQ - 1)) ? '0 : cand + 1'b1;
      if (!found && req[cand]) begin
        found        = 1'b1;
        win[cand]    = 1'b1;
        win_idx      = cand;
      end
    end
  end

endmodule

// File: rtl/log_mult_scheduler.sv
// Round-robin scheduler sharing one log_multiplier among N_REQ requesters through
// a two-stage pipeline (S1 operands, S2 tagged result) with response backpressure.
module log_mult_scheduler
  import log_mult_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int ID_W  = $clog2(N_REQ)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [N_REQ-1:0]          req_valid,
  input  logic [N_REQ-1:0][OP_W-1:0] req_a,
  input  logic [N_REQ-1:0][OP_W-1:0] req_b,
  output logic [N_REQ-1:0]          req_ready,
  output logic                      rsp_valid,
  output logic [ID_W-1:0]           rsp_id,
  output res_t                      rsp_result,
  input  logic                      rsp_ready,
  output logic                      busy
);

  s1_t              s1_q, s1_d;
  logic             s2_valid_q, s2_valid_d;
  logic [ID_W-1:0]  s2_id_q, s2_id_d;
  res_t             s2_res_q, s2_res_d;
  logic [ID_W-1:0]  ptr_q, ptr_d;

  logic             s1_adv, s2_adv, hs;
  logic [N_REQ-1:0] win;
  logic [ID_W-1:0]  win_idx;
  res_t             mult_out;
  logic             unused_id_bits;

  rr_arbiter #(.N_REQ(N_REQ), .IDX_W(ID_W)) u_arb (
    .req     (req_valid),
    .ptr     (ptr_q),
    .win     (win),
    .win_idx (win_idx)
  );

  log_multiplier u_mult (
    .A (s1_q.a),
    .B (s1_q.b),
    .P (mult_out)
  );

  always_comb begin
    s2_adv    = !s2_valid_q || rsp_ready;
    s1_adv    = !s1_q.valid || s2_adv;
    // rst_n gate keeps grants off while reset is held
    req_ready = win & {N_REQ{s1_adv & rst_n}};
    hs        = |req_ready;

    s1_d       = s1_q;
    ptr_d      = ptr_q;
    s2_valid_d = s2_valid_q;
    s2_id_d    = s2_id_q;
    s2_res_d   = s2_res_q;

    if (hs) begin
      s1_d.valid = 1'b1;
      s1_d.id    = ID_MAX_W'(win_idx);
      s1_d.a     = req_a[win_idx];
      s1_d.b     = req_b[win_idx];
      ptr_d      = win_idx;
    end else if (s1_adv) begin
      s1_d.valid = 1'b0;
    end

    if (s2_adv) begin
      s2_valid_d = s1_q.valid;
      s2_id_d    = ID_W'(s1_q.id);
      s2_res_d   = mult_out;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q       <= '0;
      s2_valid_q <= 1'b0;
      s2_id_q    <= '0;
      s2_res_q   <= '0;
      ptr_q      <= ID_W'(N_REQ - 1);
    end else begin
      s1_q       <= s1_d;
      s2_valid_q <= s2_valid_d;
      s2_id_q    <= s2_id_d;
      s2_res_q   <= s2_res_d;
      ptr_q      <= ptr_d;
    end
  end

  assign unused_id_bits = ^s1_q.id;

  assign rsp_valid  = s2_valid_q;
  assign rsp_id     = s2_id_q;
  assign rsp_result = s2_res_q;
  assign busy       = s1_q.valid | s2_valid_q;

endmodule

// File: tb/tb_log_mult_scheduler.sv
// Scoreboard bench for log_mult_scheduler: handshakes push hand-computed products,
// an independent monitor pops and compares every accepted response.
module tb_log_mult_scheduler;

  localparam int N = 4;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic [N-1:0]         req_valid;
  logic [N-1:0][7:0]    req_a, req_b;
  logic [N-1:0]         req_ready;
  logic                 rsp_valid;
  logic [1:0]           rsp_id;
  logic signed [15:0]   rsp_result;
  logic                 rsp_ready;
  logic                 busy;

  log_mult_scheduler #(.N_REQ(N)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_a      (req_a),
    .req_b      (req_b),
    .req_ready  (req_ready),
    .rsp_valid  (rsp_valid),
    .rsp_id     (rsp_id),
    .rsp_result (rsp_result),
    .rsp_ready  (rsp_ready),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    int                 id;
    logic signed [15:0] res;
  } exp_t;

  exp_t               sb[$];
  int                 grants[$];
  logic signed [15:0] cur_exp [N];
  int                 n_cmp  = 0;
  int                 n_fail = 0;

  task automatic check(input string name, input logic signed [31:0] act,
                       input logic signed [31:0] want);
    n_cmp++;
    if (act !== want) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, want, $time);
    end
  endtask

  // issue tracker: every granted handshake pushes its expected tagged product
  always @(negedge clk) begin
    if (rst_n) begin
      check("ready_only_if_valid", req_ready & ~req_valid, 0);
      check("ready_onehot0", $onehot0(req_ready), 1);
      for (int i = 0; i < N; i++) begin
        if (req_ready[i]) begin
          sb.push_back('{i, cur_exp[i]});
          grants.push_back(i);
        end
      end
    end
  end

  // response monitor
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && rsp_valid && rsp_ready) begin
      if (sb.size() == 0) begin
        check("rsp_unexpected", rsp_valid, 0);
      end else begin
        e = sb.pop_front();
        check("rsp_id", rsp_id, e.id);
        check("rsp_result", rsp_result, e.res);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic samp();
    @(negedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic signed [7:0] a,
                         input logic signed [7:0] b, input logic signed [15:0] e);
    req_a[i]   = a;
    req_b[i]   = b;
    cur_exp[i] = e;
  endtask

  task automatic drain(input string nm);
    for (int k = 0; k < 20 && busy; k++) tick();
    check(nm, busy, 0);
    check({nm, "_sb_empty"}, sb.size(), 0);
  endtask

  task automatic single(input int i, input logic signed [7:0] a,
                        input logic signed [7:0] b, input logic signed [15:0] e);
    tick();
    set_req(i, a, b, e);
    req_valid = 4'(1 << i);
    samp();
    check("single_ready", req_ready, 4'(1 << i));
    tick();
    req_valid = '0;
    req_a[i]  = 8'h55;
    req_b[i]  = 8'h33;
    samp();
    check("single_lat_t1_valid", rsp_valid, 0);
    check("single_lat_t1_busy", busy, 1);
    tick();
    samp();
    check("single_lat_t2_valid", rsp_valid, 1);
    tick();
    samp();
    check("single_after_valid", rsp_valid, 0);
  endtask

  initial begin
    int fair_exp [6];
    logic signed [15:0] held;
    fair_exp = '{0, 3, 0, 3, 0, 3};

    rst_n     = 1'b0;
    req_valid = '0;
    req_a     = '0;
    req_b     = '0;
    rsp_ready = 1'b1;
    for (int i = 0; i < N; i++) cur_exp[i] = '0;

    // reset and idle
    #2;
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_rsp_id", rsp_id, 0);
    check("rst_rsp_result", rsp_result, 0);
    check("rst_busy", busy, 0);
    req_valid = '1;
    #1;
    check("rst_req_ready", req_ready, 0);
    req_valid = '0;
    tick();
    tick();
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      samp();
      check("idle_rsp_valid", rsp_valid, 0);
      check("idle_req_ready", req_ready, 0);
      check("idle_busy", busy, 0);
    end

    // single requests on requester 1
    single(1, 8'sd4, 8'sd8, 16'sd32);
    single(1, -8'sd4, 8'sd8, -16'sd32);
    single(1, 8'sd0, 8'sd57, 16'sd0);

    // all four continuously; ptr is 1 so rotation starts at 2
    set_req(0, 8'sd1, 8'sd2, 16'sd2);
    set_req(1, 8'sd2, 8'sd4, 16'sd8);
    set_req(2, 8'sd4, 8'sd8, 16'sd32);
    set_req(3, -8'sd8, 8'sd16, -16'sd128);
    tick();
    grants.delete();
    req_valid = '1;
    for (int k = 0; k < 12; k++) begin
      samp();
      if (k >= 2) check("tput_rsp_valid", rsp_valid, 1);
      tick();
    end
    req_valid = '0;
    check("tput_grant_count", grants.size(), 12);
    for (int k = 0; k < grants.size(); k++) check("tput_grant_order", grants[k], (2 + k) % 4);
    drain("tput_drain");

    // backpressure
    tick();
    req_valid = '1;
    samp(); tick();
    samp(); tick();
    samp();
    check("bp_pre_valid", rsp_valid, 1);
    tick();
    rsp_ready = 1'b0;
    samp();
    held = rsp_result;
    check("bp_held_is_front", held, (sb.size() > 0) ? sb[0].res : 16'sh7fff);
    for (int k = 0; k < 5; k++) begin
      check("bp_req_ready", req_ready, 0);
      check("bp_rsp_valid", rsp_valid, 1);
      check("bp_result_stable", rsp_result, held);
      check("bp_entries_held", sb.size(), 2);
      check("bp_busy", busy, 1);
      tick();
      samp();
    end
    tick();
    rsp_ready = 1'b1;
    req_valid = '0;
    drain("bp_drain");

    // reset while both stages hold entries
    tick();
    req_valid = '1;
    samp(); tick();
    samp(); tick();
    samp();
    check("mid_pre_busy", busy, 1);
    check("mid_pre_valid", rsp_valid, 1);
    tick();
    #2;
    rst_n = 1'b0;
    sb.delete();
    #1;
    check("mid_rst_rsp_valid", rsp_valid, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_req_ready", req_ready, 0);
    check("mid_rst_rsp_result", rsp_result, 0);
    tick();
    tick();
    check("mid_rst_hold_ready", req_ready, 0);
    rst_n = 1'b1;
    grants.delete();
    samp();
    check("post_rst_rsp_valid", rsp_valid, 0);
    check("post_rst_grant_count", grants.size(), 1);
    if (grants.size() > 0) check("post_rst_first_grant", grants[0], 0);
    tick();
    req_valid = '0;
    drain("post_rst_drain");

    // single requester granted every cycle, then fairness with requester 0
    tick();
    grants.delete();
    req_valid = 4'b1000;
    for (int k = 0; k < 4; k++) begin samp(); tick(); end
    check("solo_grant_count", grants.size(), 4);
    for (int k = 0; k < grants.size(); k++) check("solo_grant", grants[k], 3);
    grants.delete();
    req_valid = 4'b1001;
    for (int k = 0; k < 6; k++) begin samp(); tick(); end
    req_valid = '0;
    check("fair_grant_count", grants.size(), 6);
    for (int k = 0; k < grants.size() && k < 6; k++) check("fair_grant", grants[k], fair_exp[k]);
    drain("fair_drain");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
